// File: rtl/binoc_channel_ctrl.sv
// Purpose : ownership arbiter for one end of a shared bidirectional link between two NoC routers.
// Latency : OUT_IDLE->OUT_ACTIVE 1 cycle; IN->OUT_ACTIVE 3 cycles plus the neighbour's grant delay.
// Backpressure: local_busy holds off any release so a packet is never split; starvation forces release at a packet boundary.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   local_req         - local output port has flits queued for the shared channel
//   local_busy        - a local packet is in flight (head sent, tail not yet sent)
//   nbr_req_in        - neighbour asks for the channel
//   nbr_grant_in      - one-cycle pulse: neighbour hands the channel to us
//   nbr_req_out       - we ask the neighbour for the channel
//   nbr_grant_out     - one-cycle pulse: we hand the channel to the neighbour
//   dir_out / dir_in  - channel drive enable / receive enable (never both high)
//   state_o           - current FSM state, debug only
module binoc_channel_ctrl #(
  parameter bit HP_INIT    = 1'b1,
  parameter int HOLD_MIN   = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       local_req,
  input  logic       local_busy,
  input  logic       nbr_req_in,
  input  logic       nbr_grant_in,
  output logic       nbr_req_out,
  output logic       nbr_grant_out,
  output logic       dir_out,
  output logic       dir_in,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    OUT_IDLE   = 3'd0,
    OUT_ACTIVE = 3'd1,
    RELEASE    = 3'd2,
    IN         = 3'd3,
    REQ        = 3'd4,
    TURN_IN    = 3'd5
  } state_t;

  localparam int HOLD_W   = (HOLD_MIN   < 1) ? 1 : $clog2(HOLD_MIN + 1);
  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  localparam logic [HOLD_W-1:0]   HOLD_LIM   = HOLD_W'(HOLD_MIN);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  localparam state_t RESET_STATE = HP_INIT ? OUT_IDLE : IN;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                dir_out_q, dir_out_d;
  logic                dir_in_q, dir_in_d;
  logic                nbr_req_out_q, nbr_req_out_d;
  logic                nbr_grant_out_q, nbr_grant_out_d;

  logic hold_sat;
  logic starve_sat;

  assign hold_sat   = (hold_cnt_q >= HOLD_LIM);
  assign starve_sat = (starve_cnt_q >= STARVE_LIM);

  // Next-state and counter logic.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = '0;
    starve_cnt_d = '0;

    case (state_q)
      OUT_IDLE: begin
        // The owner has priority when both sides ask in the same cycle.
        if (local_req) begin
          state_d = OUT_ACTIVE;
        end else if (nbr_req_in) begin
          state_d = RELEASE;
        end
      end

      OUT_ACTIVE: begin
        hold_cnt_d = hold_sat ? hold_cnt_q : hold_cnt_q + 1'b1;
        if (!nbr_req_in) begin
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = starve_sat ? starve_cnt_q : starve_cnt_q + 1'b1;
        end

        // A packet in flight pins the channel; every exit waits for a packet boundary.
        if (!local_busy) begin
          if (starve_sat) begin
            state_d = RELEASE;
          end else if (!local_req) begin
            if (!nbr_req_in) begin
              state_d = OUT_IDLE;
            end else if (hold_sat) begin
              state_d = RELEASE;
            end
          end
        end
      end

      RELEASE: state_d = IN;

      IN: begin
        if (local_req) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (nbr_grant_in) begin
          state_d = TURN_IN;
        end else if (!local_req) begin
          state_d = IN;
        end
      end

      TURN_IN: state_d = OUT_ACTIVE;

      default: state_d = RESET_STATE;
    endcase

    // Counters only carry meaning while staying in OUT_ACTIVE; every entry starts from zero.
    if (state_d != OUT_ACTIVE || state_q != OUT_ACTIVE) begin
      hold_cnt_d   = '0;
      starve_cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    dir_out_d       = (state_d == OUT_IDLE) || (state_d == OUT_ACTIVE);
    dir_in_d        = (state_d == IN) || (state_d == REQ);
    nbr_req_out_d   = (state_d == REQ);
    nbr_grant_out_d = (state_d == RELEASE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= RESET_STATE;
      hold_cnt_q      <= '0;
      starve_cnt_q    <= '0;
      dir_out_q       <= HP_INIT;
      dir_in_q        <= ~HP_INIT;
      nbr_req_out_q   <= 1'b0;
      nbr_grant_out_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      starve_cnt_q    <= starve_cnt_d;
      dir_out_q       <= dir_out_d;
      dir_in_q        <= dir_in_d;
      nbr_req_out_q   <= nbr_req_out_d;
      nbr_grant_out_q <= nbr_grant_out_d;
    end
  end

  assign state_o       = state_q;
  assign dir_out       = dir_out_q;
  assign dir_in        = dir_in_q;
  assign nbr_req_out   = nbr_req_out_q;
  assign nbr_grant_out = nbr_grant_out_q;

endmodule

// File: tb/tb_binoc_channel_ctrl.sv
// Purpose : self-checking bench for binoc_channel_ctrl, one owner-side and one neighbour-side instance.
// Latency : checks sampled 1 time unit after each rising clk edge.
// Backpressure: local_busy patterns exercise packet-boundary release and starvation.
module tb_binoc_channel_ctrl;

  localparam int HOLD_MIN   = 4;
  localparam int STARVE_MAX = 16;

  localparam int S_IDLE = 0;
  localparam int S_ACT  = 1;
  localparam int S_REL  = 2;
  localparam int S_IN   = 3;
  localparam int S_REQ  = 4;
  localparam int S_TURN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Owner-side instance (HP_INIT=1)
  logic       rst, local_req, local_busy, nbr_req_in, nbr_grant_in;
  logic       nbr_req_out, nbr_grant_out, dir_out, dir_in;
  logic [2:0] state_o;

  // Neighbour-side instance (HP_INIT=0)
  logic       b_rst, b_local_req, b_local_busy, b_nbr_req_in, b_nbr_grant_in;
  logic       b_nbr_req_out, b_nbr_grant_out, b_dir_out, b_dir_in;
  logic [2:0] b_state_o;

  int errors = 0;
  int checks = 0;

  binoc_channel_ctrl #(.HP_INIT(1'b1), .HOLD_MIN(HOLD_MIN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .local_req(local_req), .local_busy(local_busy),
    .nbr_req_in(nbr_req_in), .nbr_grant_in(nbr_grant_in),
    .nbr_req_out(nbr_req_out), .nbr_grant_out(nbr_grant_out),
    .dir_out(dir_out), .dir_in(dir_in), .state_o(state_o)
  );

  binoc_channel_ctrl #(.HP_INIT(1'b0), .HOLD_MIN(HOLD_MIN), .STARVE_MAX(STARVE_MAX)) dut0 (
    .clk(clk), .rst(b_rst), .local_req(b_local_req), .local_busy(b_local_busy),
    .nbr_req_in(b_nbr_req_in), .nbr_grant_in(b_nbr_grant_in),
    .nbr_req_out(b_nbr_req_out), .nbr_grant_out(b_nbr_grant_out),
    .dir_out(b_dir_out), .dir_in(b_dir_in), .state_o(b_state_o)
  );

  // Observed bundle: {state, dir_out, dir_in, nbr_req_out, nbr_grant_out}
  wire [6:0] obs   = {state_o, dir_out, dir_in, nbr_req_out, nbr_grant_out};
  wire [6:0] b_obs = {b_state_o, b_dir_out, b_dir_in, b_nbr_req_out, b_nbr_grant_out};

  // What every output must read while sitting in a given state.
  function automatic logic [6:0] exp_vec(input int st);
    logic [2:0] s;
    s = st[2:0];
    return {s, (st == S_IDLE) || (st == S_ACT), (st == S_IN) || (st == S_REQ),
            (st == S_REQ), (st == S_REL)};
  endfunction

  // Reference model: one cycle of the ownership rules, with counters as plain integers.
  task automatic model_next(input int st, input int hold, input int starve,
                            input bit lr, input bit lb, input bit nr, input bit ng,
                            output int nst, output int nhold, output int nstarve);
    nst     = st;
    nhold   = 0;
    nstarve = 0;
    if (st == S_IDLE) begin
      if (lr) nst = S_ACT;
      else if (nr) nst = S_REL;
    end else if (st == S_ACT) begin
      nhold   = (hold + 1 > HOLD_MIN) ? HOLD_MIN : hold + 1;
      nstarve = nr ? ((starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1) : 0;
      if (!lb) begin
        if (starve == STARVE_MAX) nst = S_REL;
        else if (!lr && !nr) nst = S_IDLE;
        else if (!lr && nr && hold >= HOLD_MIN) nst = S_REL;
      end
      if (nst != S_ACT) begin
        nhold   = 0;
        nstarve = 0;
      end
    end else if (st == S_REL) begin
      nst = S_IN;
    end else if (st == S_IN) begin
      if (lr) nst = S_REQ;
    end else if (st == S_REQ) begin
      if (ng) nst = S_TURN;
      else if (!lr) nst = S_IN;
    end else if (st == S_TURN) begin
      nst = S_ACT;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    local_req = 0; local_busy = 0; nbr_req_in = 0; nbr_grant_in = 0;
  endtask

  task automatic reset_owner();
    clear_inputs();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    b_local_req = 0; b_local_busy = 0; b_nbr_req_in = 0; b_nbr_grant_in = 0;
    rst = 1; b_rst = 1;
    #2;
    rst = 0; b_rst = 0;
    #1;
    checks++;
    if (obs !== exp_vec(S_IDLE)) begin
      errors++; $display("FAIL reset_hp1: got %b want %b", obs, exp_vec(S_IDLE));
    end
    checks++;
    if (b_obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL reset_hp0: got %b want %b", b_obs, exp_vec(S_IN));
    end
    tick();
    rst = 1; b_rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec(S_IDLE) || b_obs !== exp_vec(S_IN)) begin
        errors++; $display("FAIL reset_quiet[%0d]: got %b/%b want %b/%b", i, obs, b_obs,
                           exp_vec(S_IDLE), exp_vec(S_IN));
      end
    end
  endtask

  task automatic test_idle_tie();
    reset_owner();
    local_req = 1; nbr_req_in = 1;
    tick();
    checks++;
    if (obs !== exp_vec(S_ACT)) begin
      errors++; $display("FAIL idle_tie: got %b want %b", obs, exp_vec(S_ACT));
    end
  endtask

  task automatic test_active_to_idle();
    reset_owner();
    local_req = 1;
    tick();
    local_req = 0; local_busy = 1;
    tick();
    checks++;
    if (obs !== exp_vec(S_ACT)) begin
      errors++; $display("FAIL idle_busy_hold: got %b want %b", obs, exp_vec(S_ACT));
    end
    local_busy = 0;
    tick();
    checks++;
    if (obs !== exp_vec(S_IDLE)) begin
      errors++; $display("FAIL active_to_idle: got %b want %b", obs, exp_vec(S_IDLE));
    end
  endtask

  task automatic test_idle_nbr();
    reset_owner();
    nbr_req_in = 1;
    tick();
    checks++;
    if (obs !== exp_vec(S_REL)) begin
      errors++; $display("FAIL idle_nbr_rel: got %b want %b", obs, exp_vec(S_REL));
    end
    nbr_req_in = 0;
    tick();
    checks++;
    if (obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL idle_nbr_in: got %b want %b", obs, exp_vec(S_IN));
    end
  endtask

  task automatic test_hold_min();
    reset_owner();
    local_req = 1;
    tick();
    local_req = 0; nbr_req_in = 1;
    for (int i = 0; i < HOLD_MIN; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec(S_ACT)) begin
        errors++; $display("FAIL hold_min_stay[%0d]: got %b want %b", i, obs, exp_vec(S_ACT));
      end
    end
    tick();
    checks++;
    if (obs !== exp_vec(S_REL)) begin
      errors++; $display("FAIL hold_min_rel: got %b want %b", obs, exp_vec(S_REL));
    end
  endtask

  // Owner streams for 6 cycles, then yields to a waiting neighbour.
  task automatic test_release();
    reset_owner();
    local_req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec(S_ACT)) begin
        errors++; $display("FAIL release_active[%0d]: got %b want %b", i, obs, exp_vec(S_ACT));
      end
    end
    local_req = 0; nbr_req_in = 1;
    tick();
    checks++;
    if (obs !== exp_vec(S_REL)) begin
      errors++; $display("FAIL release_pulse: got %b want %b", obs, exp_vec(S_REL));
    end
    tick();
    checks++;
    if (obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL release_in: got %b want %b", obs, exp_vec(S_IN));
    end
    // Neighbour request is meaningless once we are receiving.
    tick();
    checks++;
    if (obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL in_ignore_nbr_req: got %b want %b", obs, exp_vec(S_IN));
    end
  endtask

  // Continues from IN: request the channel back and take it on the grant pulse.
  task automatic test_turn_in();
    nbr_req_in = 0; nbr_grant_in = 1;
    tick();
    nbr_grant_in = 0;
    checks++;
    if (obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL in_ignore_grant: got %b want %b", obs, exp_vec(S_IN));
    end
    local_req = 1;
    tick();
    checks++;
    if (obs !== exp_vec(S_REQ)) begin
      errors++; $display("FAIL turn_req: got %b want %b", obs, exp_vec(S_REQ));
    end
    tick();
    checks++;
    if (obs !== exp_vec(S_REQ)) begin
      errors++; $display("FAIL turn_req_wait: got %b want %b", obs, exp_vec(S_REQ));
    end
    nbr_grant_in = 1;
    tick();
    nbr_grant_in = 0;
    checks++;
    if (obs !== exp_vec(S_TURN)) begin
      errors++; $display("FAIL turn_in: got %b want %b", obs, exp_vec(S_TURN));
    end
    tick();
    checks++;
    if (obs !== exp_vec(S_ACT)) begin
      errors++; $display("FAIL turn_active: got %b want %b", obs, exp_vec(S_ACT));
    end
  endtask

  // Continues from a fresh OUT_ACTIVE with local_req held high.
  task automatic test_starve();
    logic [31:0] iv;
    nbr_req_in = 1;
    for (int i = 1; i <= STARVE_MAX + 1; i++) begin
      iv = i;
      local_busy = (i == STARVE_MAX + 1) ? 1'b1 : iv[0];
      tick();
      checks++;
      if (obs !== exp_vec(S_ACT)) begin
        errors++; $display("FAIL starve_hold[%0d]: got %b want %b", i, obs, exp_vec(S_ACT));
      end
    end
    local_busy = 0;
    tick();
    checks++;
    if (obs !== exp_vec(S_REL)) begin
      errors++; $display("FAIL starve_release: got %b want %b", obs, exp_vec(S_REL));
    end
    clear_inputs();
    tick();
    checks++;
    if (obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL starve_in: got %b want %b", obs, exp_vec(S_IN));
    end
  endtask

  task automatic test_reset_mid_req();
    b_local_req = 1;
    tick();
    checks++;
    if (b_obs !== exp_vec(S_REQ)) begin
      errors++; $display("FAIL midreq_req: got %b want %b", b_obs, exp_vec(S_REQ));
    end
    #2;
    b_rst = 0;
    #1;
    checks++;
    if (b_obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL midreq_async: got %b want %b", b_obs, exp_vec(S_IN));
    end
    tick();
    b_rst = 1; b_local_req = 0; b_nbr_grant_in = 1;
    tick();
    b_nbr_grant_in = 0;
    checks++;
    if (b_obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL midreq_stray_grant: got %b want %b", b_obs, exp_vec(S_IN));
    end
    tick();
    checks++;
    if (b_obs !== exp_vec(S_IN)) begin
      errors++; $display("FAIL midreq_settle: got %b want %b", b_obs, exp_vec(S_IN));
    end
  endtask

  task automatic test_random();
    int m_st, m_hold, m_starve;
    int n_st, n_hold, n_starve;
    int p_lr, p_lb, p_nr;
    reset_owner();
    m_st = S_IDLE; m_hold = 0; m_starve = 0;
    p_lr = 50; p_lb = 30; p_nr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        p_lr = $urandom_range(0, 100);
        p_lb = $urandom_range(0, 80);
        p_nr = $urandom_range(0, 100);
      end
      local_req    = ($urandom_range(0, 99) < p_lr);
      local_busy   = ($urandom_range(0, 99) < p_lb);
      nbr_req_in   = ($urandom_range(0, 99) < p_nr);
      nbr_grant_in = ($urandom_range(0, 99) < 30);
      model_next(m_st, m_hold, m_starve, local_req, local_busy, nbr_req_in, nbr_grant_in,
                 n_st, n_hold, n_starve);
      tick();
      m_st = n_st; m_hold = n_hold; m_starve = n_starve;
      checks++;
      if (obs !== exp_vec(m_st)) begin
        errors++; $display("FAIL random[%0d]: got %b want %b", i, obs, exp_vec(m_st));
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_idle_tie();
    test_active_to_idle();
    test_idle_nbr();
    test_hold_min();
    test_release();
    test_turn_in();
    test_starve();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
